// File: rtl/alu_inmediate_pkg.sv
// rtl/alu_inmediate_pkg.sv - shared state encoding and field widths for the ALU-immediate sequencer
package alu_inmediate_pkg;

    localparam int REG_IDX_W = 2;
    localparam int PARAM_W   = 6;
    localparam int REG_COUNT = 1 << REG_IDX_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_A   = 3'd1,
        LOAD_IMM = 3'd2,
        EXEC     = 3'd3,
        WRITE    = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/alu_inmediate_reg_sel_decoder.sv
// rtl/alu_inmediate_reg_sel_decoder.sv - 2-to-4 one-hot register select decoder with enable
module reg_sel_decoder
    import alu_inmediate_pkg::*;
(
    input  logic                 en,
    input  logic [REG_IDX_W-1:0] idx,
    output logic [REG_COUNT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_inmediate.sv
// rtl/alu_inmediate.sv - Moore control FSM for register-plus-immediate ALU instructions
// Optional FETCH_SYNC_EN: launch additionally waits for donefetch.
module alu_inmediate
    import alu_inmediate_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               donefetch,
    input  logic               start,
    input  logic [PARAM_W-1:0] parameter1,
    input  logic [PARAM_W-1:0] parameter2,
    output logic               r0in,
    output logic               r1in,
    output logic               r2in,
    output logic               r3in,
    output logic               R0OutEn,
    output logic               R1OutEn,
    output logic               R2OutEn,
    output logic               R3OutEn,
    output logic               ALUinR1,
    output logic               ALUinR2,
    output logic               ALUoutEn,
    output logic               Regiout,
    output logic               Regiin,
    output logic               done,
    output logic               inmtobuff,
    output logic               inmtoalu
);

    state_t               state;
    logic [REG_IDX_W-1:0] sel;
    logic                 launch;
    logic [REG_COUNT-1:0] out_en;
    logic [REG_COUNT-1:0] load_en;

`ifdef FETCH_SYNC_EN
    assign launch = start & donefetch;
    logic unused_inputs;
    assign unused_inputs = &{1'b0, parameter1[PARAM_W-1:REG_IDX_W], parameter2};
`else
    assign launch = start;
    logic unused_inputs;
    assign unused_inputs = &{1'b0, donefetch, parameter1[PARAM_W-1:REG_IDX_W], parameter2};
`endif

    // sel is captured only on launch so operand edits mid-instruction cannot retarget the write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state <= LOAD_A;
                        sel   <= parameter1[REG_IDX_W-1:0];
                    end
                end
                LOAD_A:   state <= LOAD_IMM;
                LOAD_IMM: state <= EXEC;
                EXEC:     state <= WRITE;
                WRITE:    state <= DONE;
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default:  state <= IDLE;
            endcase
        end
    end

    reg_sel_decoder u_out_dec (
        .en     (state == LOAD_A),
        .idx    (sel),
        .onehot (out_en)
    );

    reg_sel_decoder u_load_dec (
        .en     (state == WRITE),
        .idx    (sel),
        .onehot (load_en)
    );

    assign R0OutEn   = out_en[0];
    assign R1OutEn   = out_en[1];
    assign R2OutEn   = out_en[2];
    assign R3OutEn   = out_en[3];
    assign r0in      = load_en[0];
    assign r1in      = load_en[1];
    assign r2in      = load_en[2];
    assign r3in      = load_en[3];

    assign ALUinR1   = (state == LOAD_A);
    assign ALUinR2   = (state == LOAD_IMM);
    assign inmtobuff = (state == LOAD_IMM);
    assign inmtoalu  = (state == LOAD_IMM);
    assign ALUoutEn  = (state == EXEC);
    assign Regiin    = (state == EXEC);
    assign Regiout   = (state == WRITE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_alu_inmediate.sv
// tb/tb_alu_inmediate.sv - directed self-checking bench for alu_inmediate
module tb_alu_inmediate;
    import alu_inmediate_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       donefetch = 1'b0;
    logic       start = 1'b0;
    logic [5:0] parameter1 = '0;
    logic [5:0] parameter2 = '0;
    logic r0in, r1in, r2in, r3in;
    logic R0OutEn, R1OutEn, R2OutEn, R3OutEn;
    logic ALUinR1, ALUinR2, ALUoutEn, Regiout, Regiin, done, inmtobuff, inmtoalu;

    int total = 0;
    int bad   = 0;

    // bit order: r0in r1in r2in r3in R0..R3OutEn ALUinR1 ALUinR2 ALUoutEn Regiout Regiin done inmtobuff inmtoalu
    logic [15:0] outs;
    assign outs = {r0in, r1in, r2in, r3in, R0OutEn, R1OutEn, R2OutEn, R3OutEn,
                   ALUinR1, ALUinR2, ALUoutEn, Regiout, Regiin, done, inmtobuff, inmtoalu};

    localparam logic [15:0] E_IDLE   = 16'b0000_0000_0000_0000;
    localparam logic [15:0] E_LA_R0  = 16'b0000_1000_1000_0000;
    localparam logic [15:0] E_LA_R1  = 16'b0000_0100_1000_0000;
    localparam logic [15:0] E_LA_R2  = 16'b0000_0010_1000_0000;
    localparam logic [15:0] E_LA_R3  = 16'b0000_0001_1000_0000;
    localparam logic [15:0] E_IMM    = 16'b0000_0000_0100_0011;
    localparam logic [15:0] E_EXEC   = 16'b0000_0000_0010_1000;
    localparam logic [15:0] E_WR_R0  = 16'b1000_0000_0001_0000;
    localparam logic [15:0] E_WR_R2  = 16'b0010_0000_0001_0000;
    localparam logic [15:0] E_WR_R3  = 16'b0001_0000_0001_0000;
    localparam logic [15:0] E_DONE   = 16'b0000_0000_0000_0100;

    always #5 clk = ~clk;

    alu_inmediate dut (
        .clk        (clk),
        .rst        (rst),
        .donefetch  (donefetch),
        .start      (start),
        .parameter1 (parameter1),
        .parameter2 (parameter2),
        .r0in       (r0in),
        .r1in       (r1in),
        .r2in       (r2in),
        .r3in       (r3in),
        .R0OutEn    (R0OutEn),
        .R1OutEn    (R1OutEn),
        .R2OutEn    (R2OutEn),
        .R3OutEn    (R3OutEn),
        .ALUinR1    (ALUinR1),
        .ALUinR2    (ALUinR2),
        .ALUoutEn   (ALUoutEn),
        .Regiout    (Regiout),
        .Regiin     (Regiin),
        .done       (done),
        .inmtobuff  (inmtobuff),
        .inmtoalu   (inmtoalu)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; donefetch = 1'b0;
        tick();
        total++;
        if (outs !== E_IDLE) begin
            bad++; $display("FAIL reset_outs got=%b want=%b", outs, E_IDLE);
        end
        total++;
        if (dut.state !== IDLE) begin
            bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state, IDLE);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (outs !== E_IDLE) begin
                bad++; $display("FAIL idle_after_reset[%0d] got=%b want=%b", i, outs, E_IDLE);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp_seq [5];
        exp_seq = '{E_LA_R0, E_IMM, E_EXEC, E_WR_R0, E_DONE};
        parameter1 = 6'b000000; parameter2 = 6'b000011;
        start = 1'b1; donefetch = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            total++;
            if (outs !== exp_seq[i]) begin
                bad++; $display("FAIL basic_r0 step%0d got=%b want=%b", i, outs, exp_seq[i]);
            end
        end
        tick();
        total++;
        if (outs !== E_IDLE) begin
            bad++; $display("FAIL basic_return_idle got=%b want=%b", outs, E_IDLE);
        end
    endtask

    task automatic test_reg_select();
        logic [15:0] exp_seq [5];
        exp_seq = '{E_LA_R3, E_IMM, E_EXEC, E_WR_R3, E_DONE};
        parameter1 = 6'b000011; start = 1'b1; donefetch = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            if (i == 2) parameter1 = 6'b000001;
            total++;
            if (outs !== exp_seq[i]) begin
                bad++; $display("FAIL regsel_r3 step%0d got=%b want=%b", i, outs, exp_seq[i]);
            end
        end
        tick();
    endtask

    task automatic test_held_start();
        logic [15:0] exp_seq [5];
        exp_seq = '{E_LA_R2, E_IMM, E_EXEC, E_WR_R2, E_DONE};
        parameter1 = 6'b111110; start = 1'b1; donefetch = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (outs !== exp_seq[i]) begin
                bad++; $display("FAIL held_seq step%0d got=%b want=%b", i, outs, exp_seq[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (outs !== E_DONE) begin
                bad++; $display("FAIL held_done[%0d] got=%b want=%b", i, outs, E_DONE);
            end
        end
        start = 1'b0;
        tick();
        total++;
        if (outs !== E_IDLE) begin
            bad++; $display("FAIL held_release_idle got=%b want=%b", outs, E_IDLE);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (outs !== E_LA_R2) begin
            bad++; $display("FAIL relaunch got=%b want=%b", outs, E_LA_R2);
        end
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (outs !== E_DONE) begin
            bad++; $display("FAIL relaunch_done got=%b want=%b", outs, E_DONE);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        parameter1 = 6'b000001; start = 1'b1; donefetch = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (outs !== E_LA_R1) begin
            bad++; $display("FAIL midrst_load_a got=%b want=%b", outs, E_LA_R1);
        end
        tick();
        tick();
        total++;
        if (outs !== E_EXEC) begin
            bad++; $display("FAIL midrst_exec got=%b want=%b", outs, E_EXEC);
        end
        rst = 1'b1;
        tick();
        total++;
        if (outs !== E_IDLE || dut.state !== IDLE) begin
            bad++; $display("FAIL midrst_cleared got=%b want=%b", outs, E_IDLE);
        end
        start = 1'b1;
        tick();
        total++;
        if (outs !== E_IDLE) begin
            bad++; $display("FAIL reset_beats_start got=%b want=%b", outs, E_IDLE);
        end
        rst = 1'b0; start = 1'b0;
        tick();
        total++;
        if (outs !== E_IDLE) begin
            bad++; $display("FAIL post_reset_idle got=%b want=%b", outs, E_IDLE);
        end
    endtask

    task automatic test_gating();
        parameter1 = 6'b000000; start = 1'b1; donefetch = 1'b0;
`ifdef FETCH_SYNC_EN
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (outs !== E_IDLE) begin
                bad++; $display("FAIL gate_hold[%0d] got=%b want=%b", i, outs, E_IDLE);
            end
        end
        donefetch = 1'b1;
`endif
        tick();
        start = 1'b0;
        total++;
        if (outs !== E_LA_R0) begin
            bad++; $display("FAIL gate_launch got=%b want=%b", outs, E_LA_R0);
        end
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (outs !== E_IDLE) begin
            bad++; $display("FAIL gate_end_idle got=%b want=%b", outs, E_IDLE);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_reg_select();
        test_held_start();
        test_mid_reset();
        test_gating();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
